gamma_wave_scheduler: RTL and testbench
=======================================

// Module: gamma_wave_scheduler
// PURPOSE
//  Sequences gamma-cycle computational waves for the two-network multiplexed TNN column.
//  Generates the wave framing consumed by the column: 1-cycle grst pulse, cycle_counter and
//  alt_grst context select (alt_grst=1 -> network 1 weights/w_init, 0 -> network 0).
//  Arbitrates the shared column between two per-network volley requesters using round-robin
//  or an optional context lock. Reports per-context completions.
// PARAMETERS
//  GAMMA_CYCLE_LENGTH  18  clk cycles per wave, grst cycle included; legal range >= 3
//  CW   $clog2(GAMMA_CYCLE_LENGTH)  cycle_counter width
//  WCNT_W  16  width of per-context wave completion counters
// PORTS
//  clk            in   1       unit clock
//  rstb           in   1       synchronous reset, active-high
//  enable         in   1       permits new waves; an in-flight wave always completes
//  req            in   2       req[c]=1: volley for network c pending; held until ack[c]
//  ctx_lock       in   1       1: only ctx_sel may be granted; RR pointer frozen
//  ctx_sel        in   1       locked context, sampled at each grant decision
//  ack            out  2       1-cycle pulse on grant; requester drives volley in that wave
//  grst           out  1       1-cycle wave-start pulse to column
//  alt_grst       out  1       context of current/last wave; stable for whole wave
//  cycle_counter  out  CW      0 on grst cycle, +1 per clk, last value GAMMA_CYCLE_LENGTH-1
//  busy           out  1       1 while in GRST or RUN
//  wave_done      out  1       1-cycle pulse on final RUN cycle (counter == LEN-1)
//  done_ctx       out  1       context finishing; valid with wave_done
//  wave_cnt0/1    out  WCNT_W  completed waves per context; wrap modulo 2^WCNT_W
// BEHAVIOUR
//  Reset (rstb=1 at posedge): state IDLE; ack,grst,alt_grst,cycle_counter,busy,wave_done,
//   done_ctx=0; wave_cnt0/1=0; RR priority -> ctx0. Reset mid-wave aborts at once; no
//   wave_done, no count increment. Highest priority over all other inputs.
//  FSM: IDLE, GRST, RUN. All outputs registered.
//  Grant decision (evaluated in IDLE, and in RUN on the final cycle):
//   eligible = ctx_lock ? (req & onehot(ctx_sel)) : req; grant iff enable && |eligible.
//   Unlocked, both eligible: grant RR-priority context; RR priority then -> the other.
//   Unlocked, single eligible: grant it; RR priority -> the other. Locked: RR unchanged.
//  IDLE: grant -> GRST next cycle. Latency req(t, IDLE) -> grst/ack at t+1.
//  GRST (1 cycle): grst=1, ack[g]=1, alt_grst=g, cycle_counter=0, busy=1.
//  RUN: grst=0, counter increments 1..LEN-1; alt_grst held.
//   At counter==LEN-1: wave_done=1, done_ctx=alt_grst, wave_cnt[alt_grst]+=1 (next cycle visible);
//   if grant -> GRST next cycle (back-to-back, no gap; wave_done and next grst in
//   consecutive cycles), else -> IDLE with counter=0, busy=0, alt_grst retained.
//  enable low mid-wave: wave finishes normally, no further grant. req deasserted before ack:
//   no grant (requester protocol violation tolerated, not flagged).
//  ctx_lock/ctx_sel changes mid-wave take effect only at the next grant decision.
//  cycle_counter never exceeds LEN-1; wraps to 0 only via GRST or IDLE entry.
// TESTING
//  1 Reset, enable=1, req=01 one cycle-held until ack -> grst+ack=01 next cycle, alt_grst=0,
//    counter 0..17, wave_done at counter 17, done_ctx=0, wave_cnt0=1, then IDLE.
//  2 req=11 held continuously, unlocked -> grants ctx0,1,0,1; grst every 18 cycles,
//    no idle cycle between waves; alt_grst toggles only on grst cycles.
//  3 ctx_lock=1, ctx_sel=1, req=11 held -> only ack[1]; after 3 waves wave_cnt1=3, wave_cnt0=0;
//    unlock -> next grant ctx0 (RR pointer unchanged by locked grants).
//  4 Drop enable at counter 5 with req=11 -> wave completes (wave_done at 17), then IDLE, busy=0.
//  5 rstb at counter 9 of ctx1 wave -> next cycle all outputs 0, no wave_done, wave_cnt1 unchanged.
//  6 Preload wave_cnt0 to 2^WCNT_W-1 via repeated waves (small WCNT_W=2 build) -> wraps to 0.

Source files
------------

// File: rtl/gamma_wave_scheduler.sv
// Gamma-cycle wave sequencer for the two-network multiplexed TNN column.
// Frames each wave (grst, cycle_counter, alt_grst) and arbitrates the column between two volley requesters.
module gamma_wave_scheduler #(
    parameter int GAMMA_CYCLE_LENGTH = 18,
    parameter int CW                 = $clog2(GAMMA_CYCLE_LENGTH),
    parameter int WCNT_W             = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              enable,
    input  logic [1:0]        req,
    input  logic              ctx_lock,
    input  logic              ctx_sel,
    output logic [1:0]        ack,
    output logic              grst,
    output logic              alt_grst,
    output logic [CW-1:0]     cycle_counter,
    output logic              busy,
    output logic              wave_done,
    output logic              done_ctx,
    output logic [WCNT_W-1:0] wave_cnt0,
    output logic [WCNT_W-1:0] wave_cnt1,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GRST = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CW-1:0]     LAST = CW'(GAMMA_CYCLE_LENGTH - 1);
    localparam logic [CW-1:0]     CONE = CW'(1);
    localparam logic [WCNT_W-1:0] WONE = WCNT_W'(1);

    // Handshake: req[c] is held high by the requester until it sees the 1-cycle ack[c];
    // the acked requester drives its volley during the wave that ack opens.
    state_t              state_q, state_d;
    logic [1:0]          ack_q, ack_d;
    logic                grst_q, grst_d;
    logic                alt_q, alt_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                wave_done_q, wave_done_d;
    logic                done_ctx_q, done_ctx_d;
    logic [WCNT_W-1:0]   wcnt0_q, wcnt0_d;
    logic [WCNT_W-1:0]   wcnt1_q, wcnt1_d;
    logic                rr_q, rr_d;

    logic [1:0]          eligible;
    logic                decide;
    logic                grant;
    logic                gnt_ctx;

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q     <= ST_IDLE;
            ack_q       <= 2'b00;
            grst_q      <= 1'b0;
            alt_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            wave_done_q <= 1'b0;
            done_ctx_q  <= 1'b0;
            wcnt0_q     <= '0;
            wcnt1_q     <= '0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            grst_q      <= grst_d;
            alt_q       <= alt_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            wave_done_q <= wave_done_d;
            done_ctx_q  <= done_ctx_d;
            wcnt0_q     <= wcnt0_d;
            wcnt1_q     <= wcnt1_d;
            rr_q        <= rr_d;
        end
    end

    // Arbitration: a lock restricts eligibility to ctx_sel and leaves the RR pointer alone.
    always_comb begin
        eligible = ctx_lock ? (req & (ctx_sel ? 2'b10 : 2'b01)) : req;
        if (ctx_lock) begin
            gnt_ctx = ctx_sel;
        end else if (&eligible) begin
            gnt_ctx = rr_q;
        end else begin
            gnt_ctx = eligible[1];
        end
        decide = (state_q == ST_IDLE) || ((state_q == ST_RUN) && (cnt_q == LAST));
        grant  = decide && enable && (|eligible);
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = 2'b00;
        grst_d      = 1'b0;
        alt_d       = alt_q;
        cnt_d       = cnt_q;
        done_ctx_d  = done_ctx_q;
        wcnt0_d     = wcnt0_q;
        wcnt1_d     = wcnt1_q;
        rr_d        = rr_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_GRST: begin
                state_d = ST_RUN;
                cnt_d   = cnt_q + CONE;
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    if (alt_q) begin
                        wcnt1_d = wcnt1_q + WONE;
                    end else begin
                        wcnt0_d = wcnt0_q + WONE;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A grant on the final RUN cycle overrides the return to IDLE: back-to-back waves.
        if (grant) begin
            state_d = ST_GRST;
            cnt_d   = '0;
            grst_d  = 1'b1;
            ack_d   = gnt_ctx ? 2'b10 : 2'b01;
            alt_d   = gnt_ctx;
            if (!ctx_lock) begin
                rr_d = ~gnt_ctx;
            end
        end

        wave_done_d = (state_d == ST_RUN) && (cnt_d == LAST);
        if (wave_done_d) begin
            done_ctx_d = alt_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    assign ack           = ack_q;
    assign grst          = grst_q;
    assign alt_grst      = alt_q;
    assign cycle_counter = cnt_q;
    assign busy          = busy_q;
    assign wave_done     = wave_done_q;
    assign done_ctx      = done_ctx_q;
    assign wave_cnt0     = wcnt0_q;
    assign wave_cnt1     = wcnt1_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_gamma_wave_scheduler.sv
// Bench for gamma_wave_scheduler: directed scenario tasks plus randomized traffic
// checked against a wave-position reference model; a WCNT_W=2 copy exercises counter wrap.
module tb_gamma_wave_scheduler;

    localparam int LEN = 18;
    localparam int CW  = 5;

    logic        clk = 1'b0;
    logic        rstb;
    logic        enable;
    logic [1:0]  req;
    logic        ctx_lock;
    logic        ctx_sel;

    logic [1:0]  ack, ack_s;
    logic        grst, grst_s, alt_grst, alt_grst_s;
    logic [CW-1:0] cycle_counter, cycle_counter_s;
    logic        busy, busy_s, wave_done, wave_done_s, done_ctx, done_ctx_s;
    logic [15:0] wave_cnt0, wave_cnt1;
    logic [1:0]  wave_cnt0_s, wave_cnt1_s;
    logic [1:0]  dbg_state, dbg_state_s;

    int n_cmp  = 0;
    int n_fail = 0;

    gamma_wave_scheduler #(.GAMMA_CYCLE_LENGTH(LEN), .WCNT_W(16)) dut (
        .clk(clk), .rstb(rstb), .enable(enable), .req(req), .ctx_lock(ctx_lock),
        .ctx_sel(ctx_sel), .ack(ack), .grst(grst), .alt_grst(alt_grst),
        .cycle_counter(cycle_counter), .busy(busy), .wave_done(wave_done),
        .done_ctx(done_ctx), .wave_cnt0(wave_cnt0), .wave_cnt1(wave_cnt1),
        .dbg_state(dbg_state)
    );

    gamma_wave_scheduler #(.GAMMA_CYCLE_LENGTH(LEN), .WCNT_W(2)) dut_small (
        .clk(clk), .rstb(rstb), .enable(enable), .req(req), .ctx_lock(ctx_lock),
        .ctx_sel(ctx_sel), .ack(ack_s), .grst(grst_s), .alt_grst(alt_grst_s),
        .cycle_counter(cycle_counter_s), .busy(busy_s), .wave_done(wave_done_s),
        .done_ctx(done_ctx_s), .wave_cnt0(wave_cnt0_s), .wave_cnt1(wave_cnt1_s),
        .dbg_state(dbg_state_s)
    );

    always #5 clk = ~clk;

    // Reference model: m_pos is the position inside the current wave (-1 when idle).
    int          m_pos = -1;
    logic        m_ctx = 1'b0;
    logic        m_rr  = 1'b0;
    logic [31:0] m_cnt0 = 0;
    logic [31:0] m_cnt1 = 0;
    logic [1:0]  m_elig;
    logic        m_g;
    bit          m_decide;

    always @(posedge clk) begin
        if (rstb) begin
            m_pos = -1; m_ctx = 1'b0; m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_decide = (m_pos < 0) || (m_pos == LEN - 1);
            if (m_pos == LEN - 1) begin
                if (m_ctx) m_cnt1 = m_cnt1 + 1;
                else       m_cnt0 = m_cnt0 + 1;
            end
            if (!m_decide) begin
                m_pos = m_pos + 1;
            end else begin
                m_elig = ctx_lock ? (req & (2'b01 << ctx_sel)) : req;
                if (enable && m_elig != 2'b00) begin
                    if (ctx_lock)              m_g = ctx_sel;
                    else if (m_elig == 2'b11)  m_g = m_rr;
                    else                       m_g = (m_elig == 2'b10);
                    if (!ctx_lock) m_rr = ~m_g;
                    m_ctx = m_g;
                    m_pos = 0;
                end else begin
                    m_pos = -1;
                end
            end
        end
    end

    task automatic do_reset();
        rstb = 1'b1; enable = 1'b0; req = 2'b00; ctx_lock = 1'b0; ctx_sel = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b1; enable = 1'b1; req = 2'b11; ctx_lock = 1'b0; ctx_sel = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ack, grst, alt_grst, cycle_counter, busy, wave_done, done_ctx, dbg_state} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", {ack, grst, alt_grst, cycle_counter, busy, wave_done, done_ctx, dbg_state});
        end
        n_cmp++;
        if ({wave_cnt0, wave_cnt1} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts got=%h exp=0", {wave_cnt0, wave_cnt1});
        end
        rstb = 1'b0; req = 2'b00; enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_wave();
        do_reset();
        enable = 1'b1; req = 2'b01;
        @(negedge clk);
        n_cmp++;
        if ({grst, ack, alt_grst, cycle_counter, busy} !== {1'b1, 2'b01, 1'b0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grst got=%b exp=%b", {grst, ack, alt_grst, cycle_counter, busy}, {1'b1, 2'b01, 1'b0, 5'd0, 1'b1});
        end
        req = 2'b00;
        for (int i = 1; i < LEN; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({grst, cycle_counter, wave_done} !== {1'b0, CW'(i), (i == LEN - 1)}) begin
                n_fail++;
                $display("FAIL single_run i=%0d got=%b exp=%b", i, {grst, cycle_counter, wave_done}, {1'b0, CW'(i), (i == LEN - 1)});
            end
        end
        n_cmp++;
        if (done_ctx !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_ctx got=%b exp=0", done_ctx);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, cycle_counter, wave_done, dbg_state, wave_cnt0} !== {1'b0, 5'd0, 1'b0, 2'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL single_idle got=%h exp=%h", {busy, cycle_counter, wave_done, dbg_state, wave_cnt0}, {1'b0, 5'd0, 1'b0, 2'd0, 16'd1});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_v;
        int pos;
        int w;
        do_reset();
        enable = 1'b1; req = 2'b11;
        for (int k = 0; k < 4 * LEN; k++) begin
            @(negedge clk);
            pos = k % LEN;
            w = k / LEN;
            exp_v = {(pos == 0) ? ((w % 2 == 1) ? 2'b10 : 2'b01) : 2'b00, (pos == 0), (w % 2 == 1),
                     CW'(pos), (pos == LEN - 1), 1'b1};
            n_cmp++;
            if ({ack, grst, alt_grst, cycle_counter, wave_done, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL b2b k=%0d got=%b exp=%b", k, {ack, grst, alt_grst, cycle_counter, wave_done, busy}, exp_v);
            end
        end
        n_cmp++;
        if ({wave_cnt0, wave_cnt1} !== {16'd2, 16'd1}) begin
            n_fail++;
            $display("FAIL b2b_counts got=%0d/%0d exp=2/1", wave_cnt0, wave_cnt1);
        end
        req = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({busy, wave_cnt1} !== {1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL b2b_end got=%h exp=%h", {busy, wave_cnt1}, {1'b0, 16'd2});
        end
    endtask

    task automatic test_ctx_lock();
        int waves = 0;
        bit found = 0;
        do_reset();
        enable = 1'b1; ctx_lock = 1'b1; ctx_sel = 1'b1; req = 2'b11;
        for (int i = 0; i < 10 * LEN && waves < 3; i++) begin
            @(negedge clk);
            if (grst) begin
                waves++;
                n_cmp++;
                if ({ack, alt_grst} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL lock_grant wave=%0d got=%b exp=101", waves, {ack, alt_grst});
                end
            end
        end
        n_cmp++;
        if (waves != 3) begin
            n_fail++;
            $display("FAIL lock_timeout got=%0d waves exp=3", waves);
        end
        ctx_lock = 1'b0;
        for (int i = 0; i < 2 * LEN && !found; i++) begin
            @(negedge clk);
            if (grst) found = 1;
        end
        n_cmp++;
        if ({found, ack, alt_grst, wave_cnt1, wave_cnt0} !== {1'b1, 2'b01, 1'b0, 16'd3, 16'd0}) begin
            n_fail++;
            $display("FAIL unlock_grant got=%h exp=%h", {found, ack, alt_grst, wave_cnt1, wave_cnt0}, {1'b1, 2'b01, 1'b0, 16'd3, 16'd0});
        end
    endtask

    task automatic test_enable_drop();
        bit seen = 0;
        do_reset();
        enable = 1'b1; req = 2'b11;
        for (int i = 0; i < 3 * LEN && !seen; i++) begin
            @(negedge clk);
            if (busy && cycle_counter == 5'd5) seen = 1;
        end
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * LEN && !seen; i++) begin
            @(negedge clk);
            if (wave_done) seen = 1;
        end
        n_cmp++;
        if ({seen, cycle_counter, done_ctx} !== {1'b1, 5'd17, 1'b0}) begin
            n_fail++;
            $display("FAIL endrop_done got=%b exp=%b", {seen, cycle_counter, done_ctx}, {1'b1, 5'd17, 1'b0});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, grst, cycle_counter, dbg_state, wave_cnt0} !== {1'b0, 1'b0, 5'd0, 2'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL endrop_idle got=%h exp=%h", {busy, grst, cycle_counter, dbg_state, wave_cnt0}, {1'b0, 1'b0, 5'd0, 2'd0, 16'd1});
        end
    endtask

    task automatic test_reset_midwave();
        bit seen = 0;
        do_reset();
        enable = 1'b1; req = 2'b10;
        for (int i = 0; i < 3 * LEN && !seen; i++) begin
            @(negedge clk);
            if (ack[1]) req = 2'b00;
            if (busy && cycle_counter == 5'd9) seen = 1;
        end
        n_cmp++;
        if ({seen, alt_grst} !== 2'b11) begin
            n_fail++;
            $display("FAIL midrst_setup got=%b exp=11", {seen, alt_grst});
        end
        rstb = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ack, grst, alt_grst, cycle_counter, busy, wave_done, done_ctx, wave_cnt1} !== 29'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%h exp=0", {ack, grst, alt_grst, cycle_counter, busy, wave_done, done_ctx, wave_cnt1});
        end
        rstb = 1'b0; enable = 1'b0;
        repeat (LEN) @(negedge clk);
        n_cmp++;
        if ({wave_done, busy, wave_cnt1} !== 18'd0) begin
            n_fail++;
            $display("FAIL midrst_after got=%h exp=0", {wave_done, busy, wave_cnt1});
        end
    endtask

    task automatic test_wrap();
        int dones = 0;
        do_reset();
        enable = 1'b1; ctx_lock = 1'b1; ctx_sel = 1'b0; req = 2'b01;
        for (int i = 0; i < 6 * LEN && dones < 4; i++) begin
            @(negedge clk);
            if (wave_done_s) begin
                dones++;
                @(negedge clk);
                n_cmp++;
                if (wave_cnt0_s !== 2'(dones)) begin
                    n_fail++;
                    $display("FAIL wrap_cnt wave=%0d got=%0d exp=%0d", dones, wave_cnt0_s, 2'(dones));
                end
            end
        end
        n_cmp++;
        if ({dones[3:0], wave_cnt0_s, wave_cnt0} !== {4'd4, 2'd0, 16'd4}) begin
            n_fail++;
            $display("FAIL wrap_final got=%h exp=%h", {dones[3:0], wave_cnt0_s, wave_cnt0}, {4'd4, 2'd0, 16'd4});
        end
        req = 2'b00; ctx_lock = 1'b0;
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            exp_v = {(m_pos == 0) ? (m_ctx ? 2'b10 : 2'b01) : 2'b00, (m_pos == 0), m_ctx,
                     (m_pos < 0) ? 5'd0 : CW'(m_pos), (m_pos >= 0), (m_pos == LEN - 1)};
            n_cmp++;
            if ({ack, grst, alt_grst, cycle_counter, busy, wave_done} !== exp_v) begin
                n_fail++;
                $display("FAIL rand_outputs k=%0d got=%b exp=%b", k, {ack, grst, alt_grst, cycle_counter, busy, wave_done}, exp_v);
            end
            if (m_pos == LEN - 1) begin
                n_cmp++;
                if (done_ctx !== m_ctx) begin
                    n_fail++;
                    $display("FAIL rand_done_ctx k=%0d got=%b exp=%b", k, done_ctx, m_ctx);
                end
            end
            n_cmp++;
            if ({wave_cnt0, wave_cnt1, wave_cnt0_s, wave_cnt1_s} !== {m_cnt0[15:0], m_cnt1[15:0], m_cnt0[1:0], m_cnt1[1:0]}) begin
                n_fail++;
                $display("FAIL rand_counts k=%0d got=%h exp=%h", k, {wave_cnt0, wave_cnt1, wave_cnt0_s, wave_cnt1_s},
                         {m_cnt0[15:0], m_cnt1[15:0], m_cnt0[1:0], m_cnt1[1:0]});
            end
            for (int c = 0; c < 2; c++) begin
                if (ack[c])                          req[c] = ($urandom_range(0, 3) == 0);
                else if (!req[c])                    req[c] = ($urandom_range(0, 7) == 0);
                else if ($urandom_range(0, 299) == 0) req[c] = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            if ($urandom_range(0, 59) == 0) ctx_lock = ~ctx_lock;
            if ($urandom_range(0, 29) == 0) ctx_sel = ~ctx_sel;
            rstb = ($urandom_range(0, 799) == 0);
        end
        rstb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_wave();
        test_back_to_back();
        test_ctx_lock();
        test_enable_drop();
        test_reset_midwave();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
